zapper_shot_ctrl: RTL and testbench
===================================

// Module: zapper_shot_ctrl
// PURPOSE
//  Sequences one light-gun shot. Trigger press -> black flash frame(s) -> target flash frame(s),
//  then grades the photodiode detect input into a hit or miss. Sits between the gun inputs and
//  pattern_gen: drives flash_black/flash_target overrides and takes frame timing from the vga block.
//  Also tracks shots remaining and a saturating score.
// PARAMETERS
//  BLACK_FRAMES   1   full frames screen forced black before target flash (>=1)
//  TARGET_FRAMES  1   full frames target box shown while detect is sampled (>=1)
//  DETECT_MIN     16  valid-qualified detect cycles in TARGET needed for hit (>=1)
//  SHOTS          3   shots per round, reload value of shots_left (1..15)
//  SCORE_W        8   score width
// PORTS
//  clk           in   1        pixel clock (pll output)
//  reset         in   1        asynchronous, active-high reset
//  trigger       in   1        raw gun trigger, async, active-high
//  detect        in   1        raw photodiode, async, active-high = light seen
//  frame_start   in   1        1-cycle pulse at start of each frame (from vga)
//  valid         in   1        high in visible pixel area (from vga)
//  new_round     in   1        1-cycle pulse: reload shots_left, clear score
//  flash_black   out  1        pattern_gen override: whole screen black
//  flash_target  out  1        pattern_gen override: black screen, white target box
//  hit_pulse     out  1        1-cycle pulse, shot graded hit
//  miss_pulse    out  1        1-cycle pulse, shot graded miss
//  score         out  SCORE_W  hits this round, saturates at all-ones
//  shots_left    out  4        shots remaining
//  busy          out  1        high in any state except IDLE
// BEHAVIOUR
//  - trigger, detect pass 2-flop synchronizers; trig_rise = synced rising edge (3 clk after raw edge).
//  - Reset: state=IDLE, all pulses/flash/busy=0, score=0, shots_left=SHOTS, counters=0, syncs=0.
//  - All outputs registered; flash_* and busy are state decodes registered with the state.
//  - IDLE: trig_rise && shots_left!=0 -> ARM. trig_rise with shots_left==0 ignored.
//  - ARM: wait for frame_start -> BLACK, frame_cnt=0. Flash never starts mid-frame.
//  - BLACK: flash_black=1; each frame_start increments frame_cnt; on the BLACK_FRAMES-th
//    frame_start -> TARGET, frame_cnt=0, det_cnt=0.
//  - TARGET: flash_target=1; det_cnt++ on each cycle with valid && detect_s, saturating at DETECT_MIN;
//    on the TARGET_FRAMES-th frame_start -> RESULT.
//  - RESULT (1 cycle): hit if det_cnt==DETECT_MIN (and no ambient flag, see CONFIGURATION):
//    hit_pulse=1, score+1 (saturating); else miss_pulse=1. shots_left-1 either way. -> COOLDOWN.
//  - COOLDOWN: wait for synced trigger low -> IDLE (one press = one shot; no auto-fire).
//  - trig_rise outside IDLE ignored; never queued.
//  - new_round: shots_left=SHOTS, score=0, any state, no state change. If same cycle as RESULT,
//    reload/clear wins (no decrement/increment) but hit/miss pulse still emitted.
//  - Reset mid-shot: immediate return to IDLE, overrides drop, no pulse emitted.
//  - Exactly one of hit_pulse/miss_pulse per RESULT; never both, never outside RESULT.
// CONFIGURATION
//  ZAPPER_AMBIENT_REJECT_EN defined: any valid && detect_s cycle during BLACK sets ambient flag
//    (cleared on ARM->BLACK); flag set forces miss in RESULT regardless of det_cnt.
//  Not defined: detect ignored outside TARGET; grading on det_cnt only.
// TESTING
//  1 trigger rise, detect held high from BLACK through TARGET, defaults, macro off -> flash_black one
//    frame, flash_target one frame, hit_pulse 1 cycle, score 0->1, shots_left 3->2.
//  2 detect high only in TARGET for 15 valid cycles -> miss_pulse, score unchanged, shots_left-1;
//    repeat with 16 -> hit_pulse.
//  3 macro on, detect high 1 valid cycle in BLACK plus 100 in TARGET -> miss_pulse; macro off -> hit.
//  4 three shots fired, 4th trigger -> stays IDLE, busy=0, shots_left=0; new_round -> shots_left=3, score=0.
//  5 trigger held high after shot -> remains COOLDOWN; second rise mid-TARGET ignored;
//    release -> IDLE in 3 cycles.
//  6 reset asserted mid-TARGET -> next edge flash_target=0, busy=0, no hit/miss pulse,
//    shots_left=3, score=0.

Source files
------------

// File: rtl/zapper_shot_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : zapper_shot_ctrl                                               |
// | Brief   : Light-gun shot sequencer: black flash, target flash, hit grade. |
// |           Optional macro ZAPPER_AMBIENT_REJECT_EN: light seen during the  |
// |           black frames forces a miss.                                    |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module zapper_shot_ctrl #(
  parameter int BLACK_FRAMES  = 1,
  parameter int TARGET_FRAMES = 1,
  parameter int DETECT_MIN    = 16,
  parameter int SHOTS         = 3,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trigger,
  input  logic               detect,
  input  logic               frame_start,
  input  logic               valid,
  input  logic               new_round,
  output logic               flash_black,
  output logic               flash_target,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         shots_left,
  output logic               busy
);

  localparam int c_FRAME_MAX = (BLACK_FRAMES > TARGET_FRAMES) ? BLACK_FRAMES : TARGET_FRAMES;
  localparam int c_FC_W      = (c_FRAME_MAX > 1) ? $clog2(c_FRAME_MAX) : 1;
  localparam int c_DC_W      = $clog2(DETECT_MIN + 1);

  localparam logic [c_FC_W-1:0] c_BLACK_LAST  = c_FC_W'(BLACK_FRAMES - 1);
  localparam logic [c_FC_W-1:0] c_TARGET_LAST = c_FC_W'(TARGET_FRAMES - 1);
  localparam logic [c_DC_W-1:0] c_DET_MAX     = c_DC_W'(DETECT_MIN);
  localparam logic [3:0]        c_SHOTS       = 4'(SHOTS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_BLACK    = 3'd2,
    S_TARGET   = 3'd3,
    S_RESULT   = 3'd4,
    S_COOLDOWN = 3'd5
  } state_t;

  state_t              r_state;
  logic                r_trig_s1, r_trig_s2, r_trig_d;
  logic                r_det_s1, r_det_s2;
  logic [c_FC_W-1:0]   r_frame_cnt;
  logic [c_DC_W-1:0]   r_det_cnt;
  logic                w_trig_rise;
  logic                w_det_seen;
  logic [c_DC_W-1:0]   w_det_next;
  logic                w_ambient;

  assign w_trig_rise = r_trig_s2 & ~r_trig_d;
  assign w_det_seen  = valid & r_det_s2;
  assign w_det_next  = (w_det_seen && (r_det_cnt != c_DET_MAX)) ? r_det_cnt + c_DC_W'(1) : r_det_cnt;

`ifdef ZAPPER_AMBIENT_REJECT_EN
  logic r_ambient;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ambient <= 1'b0;
    end else if (r_state == S_ARM && frame_start) begin
      r_ambient <= 1'b0;
    end else if (r_state == S_BLACK && w_det_seen) begin
      r_ambient <= 1'b1;
    end
  end

  assign w_ambient = r_ambient;
`else
  assign w_ambient = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_trig_s1    <= 1'b0;
      r_trig_s2    <= 1'b0;
      r_trig_d     <= 1'b0;
      r_det_s1     <= 1'b0;
      r_det_s2     <= 1'b0;
      r_frame_cnt  <= '0;
      r_det_cnt    <= '0;
      flash_black  <= 1'b0;
      flash_target <= 1'b0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      busy         <= 1'b0;
      score        <= '0;
      shots_left   <= c_SHOTS;
    end else begin
      r_trig_s1  <= trigger;
      r_trig_s2  <= r_trig_s1;
      r_trig_d   <= r_trig_s2;
      r_det_s1   <= detect;
      r_det_s2   <= r_det_s1;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_trig_rise && shots_left != 4'd0) begin
            r_state <= S_ARM;
            busy    <= 1'b1;
          end
        end
        S_ARM: begin
          if (frame_start) begin
            r_state     <= S_BLACK;
            flash_black <= 1'b1;
            r_frame_cnt <= '0;
          end
        end
        S_BLACK: begin
          if (frame_start) begin
            if (r_frame_cnt == c_BLACK_LAST) begin
              r_state      <= S_TARGET;
              flash_black  <= 1'b0;
              flash_target <= 1'b1;
              r_frame_cnt  <= '0;
              r_det_cnt    <= '0;
            end else begin
              r_frame_cnt <= r_frame_cnt + c_FC_W'(1);
            end
          end
        end
        S_TARGET: begin
          r_det_cnt <= w_det_next;
          if (frame_start) begin
            if (r_frame_cnt == c_TARGET_LAST) begin
              // Grade here so the pulse is visible during the RESULT cycle itself
              r_state      <= S_RESULT;
              flash_target <= 1'b0;
              if (w_det_next == c_DET_MAX && !w_ambient) begin
                hit_pulse <= 1'b1;
              end else begin
                miss_pulse <= 1'b1;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + c_FC_W'(1);
            end
          end
        end
        S_RESULT: begin
          r_state <= S_COOLDOWN;
        end
        S_COOLDOWN: begin
          if (!r_trig_s2) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          flash_black  <= 1'b0;
          flash_target <= 1'b0;
          busy         <= 1'b0;
        end
      endcase

      if (new_round) begin
        shots_left <= c_SHOTS;
        score      <= '0;
      end else if (r_state == S_RESULT) begin
        if (shots_left != 4'd0) begin
          shots_left <= shots_left - 4'd1;
        end
        if (hit_pulse && score != {SCORE_W{1'b1}}) begin
          score <= score + SCORE_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zapper_shot_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_zapper_shot_ctrl                                            |
// | Brief   : Self-checking bench for zapper_shot_ctrl with a synthetic frame |
// |           generator and a shot-level outcome model.                      |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_zapper_shot_ctrl;

  localparam int FR    = 160;
  localparam int VS    = 8;
  localparam int VE    = 152;
  localparam int BF    = 1;
  localparam int TF    = 1;
  localparam int DMIN  = 16;
  localparam int NSHOT = 3;
  localparam int SW    = 8;
`ifdef ZAPPER_AMBIENT_REJECT_EN
  localparam bit AMB = 1'b1;
`else
  localparam bit AMB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, trigger, detect, frame_start, valid, new_round;
  logic          flash_black, flash_target, hit_pulse, miss_pulse, busy;
  logic [SW-1:0] score;
  logic [3:0]    shots_left;

  int errors = 0;
  int checks = 0;
  int ph;
  int nb = 0, nt = 0, nhit = 0, nmiss = 0, nboth = 0;
  int m_score, m_shots;

  zapper_shot_ctrl #(
    .BLACK_FRAMES (BF),
    .TARGET_FRAMES(TF),
    .DETECT_MIN   (DMIN),
    .SHOTS        (NSHOT),
    .SCORE_W      (SW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trigger     (trigger),
    .detect      (detect),
    .frame_start (frame_start),
    .valid       (valid),
    .new_round   (new_round),
    .flash_black (flash_black),
    .flash_target(flash_target),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .score       (score),
    .shots_left  (shots_left),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Frame timing: ph is the phase of the cycle currently running
  initial begin
    ph          = FR - 1;
    frame_start = 1'b0;
    valid       = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      ph          = (ph + 1) % FR;
      frame_start = (ph == 0);
      valid       = (ph >= VS) && (ph < VE);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (flash_black)  nb++;
      if (flash_target) nt++;
      if (hit_pulse)    nhit++;
      if (miss_pulse)   nmiss++;
      if (hit_pulse && miss_pulse) nboth++;
    end
  end

  task automatic step();
    @(posedge clk);
    #4;
  endtask

  task automatic wait_ph(input int p);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (ph != p && k <= FR);
  endtask

  task automatic model_result(input bit hit, input bit nr);
    if (nr) begin
      m_shots = NSHOT;
      m_score = 0;
    end else begin
      if (m_shots > 0) m_shots--;
      if (hit && m_score < (1 << SW) - 1) m_score++;
    end
  endtask

  task automatic do_new_round();
    step();
    new_round = 1'b1;
    step();
    new_round = 1'b0;
    m_shots = NSHOT;
    m_score = 0;
    checks++;
    if (shots_left !== 4'(m_shots) || score !== SW'(m_score))
      $display("FAIL new_round: shots=%0d score=%0d expected shots=%0d score=%0d",
               shots_left, score, m_shots, m_score);
    if (shots_left !== 4'(m_shots) || score !== SW'(m_score)) errors++;
  endtask

  // One complete shot; bn/tn are synced detect cycles inside visible area of black/target frames
  task automatic fire_shot(input int bn, input int tn, input bit hold_det,
                           input bit hold_trig, input bit dip, input bit nr);
    int  hb, ht, h0, m0, k;
    bit  exp_hit;
    exp_hit = (tn >= DMIN) && !(AMB && bn > 0);
    wait_ph(2);
    hb = nb; ht = nt; h0 = nhit; m0 = nmiss;
    trigger = 1'b1;
    if (hold_det) detect = 1'b1;
    wait_ph(0);
    checks++;
    if (busy !== 1'b1 || flash_black !== 1'b0) begin
      errors++;
      $display("FAIL arm: busy=%b flash_black=%b expected busy=1 flash_black=0", busy, flash_black);
    end
    wait_ph(20);
    checks++;
    if (flash_black !== 1'b1 || flash_target !== 1'b0) begin
      errors++;
      $display("FAIL black_frame: flash_black=%b flash_target=%b expected 1/0", flash_black, flash_target);
    end
    if (!hold_det) begin
      for (int i = 0; i < bn; i++) begin
        detect = 1'b1;
        step();
      end
      detect = 1'b0;
      wait_ph(153);
      detect = 1'b1;
      repeat (4) step();
      detect = 1'b0;
    end
    wait_ph(0);
    wait_ph(20);
    checks++;
    if (flash_target !== 1'b1 || flash_black !== 1'b0) begin
      errors++;
      $display("FAIL target_frame: flash_target=%b flash_black=%b expected 1/0", flash_target, flash_black);
    end
    if (!hold_det) begin
      for (int i = 0; i < tn; i++) begin
        detect = 1'b1;
        step();
      end
      detect = 1'b0;
    end
    if (dip) begin
      wait_ph(140);
      trigger = 1'b0;
      repeat (5) step();
      trigger = 1'b1;
    end
    if (!hold_det) begin
      wait_ph(153);
      detect = 1'b1;
      repeat (4) step();
      detect = 1'b0;
    end
    wait_ph(0);
    step();
    new_round = nr;
    checks++;
    if (hit_pulse !== exp_hit || miss_pulse !== !exp_hit) begin
      errors++;
      $display("FAIL grade: hit=%b miss=%b expected hit=%b miss=%b", hit_pulse, miss_pulse,
               exp_hit, !exp_hit);
    end
    step();
    new_round = 1'b0;
    model_result(exp_hit, nr);
    checks++;
    if (shots_left !== 4'(m_shots) || score !== SW'(m_score)) begin
      errors++;
      $display("FAIL counters: shots=%0d score=%0d expected shots=%0d score=%0d",
               shots_left, score, m_shots, m_score);
    end
    checks++;
    if ((nhit - h0) != int'(exp_hit) || (nmiss - m0) != int'(!exp_hit)) begin
      errors++;
      $display("FAIL pulse_count: hits=%0d misses=%0d expected hits=%0d misses=%0d",
               nhit - h0, nmiss - m0, exp_hit, !exp_hit);
    end
    checks++;
    if ((nb - hb) != FR * BF || (nt - ht) != FR * TF) begin
      errors++;
      $display("FAIL flash_len: black=%0d target=%0d expected black=%0d target=%0d",
               nb - hb, nt - ht, FR * BF, FR * TF);
    end
    if (hold_det) detect = 1'b0;
    if (!hold_trig) begin
      trigger = 1'b0;
      k = 0;
      while (busy && k < 10) begin
        step();
        k++;
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL cooldown_exit: busy=%b expected 0 within 10 cycles", busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; trigger = 1'b0; detect = 1'b0; new_round = 1'b0;
    repeat (3) step();
    checks++;
    if (flash_black !== 1'b0 || flash_target !== 1'b0 || hit_pulse !== 1'b0 ||
        miss_pulse !== 1'b0 || busy !== 1'b0 || score !== '0 || shots_left !== 4'(NSHOT)) begin
      errors++;
      $display("FAIL reset_state: fb=%b ft=%b hit=%b miss=%b busy=%b score=%0d shots=%0d expected 0/0/0/0/0/0/%0d",
               flash_black, flash_target, hit_pulse, miss_pulse, busy, score, shots_left, NSHOT);
    end
    reset = 1'b0;
    m_shots = NSHOT;
    m_score = 0;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || shots_left !== 4'(NSHOT)) begin
      errors++;
      $display("FAIL post_reset: busy=%b shots=%0d expected busy=0 shots=%0d", busy, shots_left, NSHOT);
    end
  endtask

  task automatic test_single_hit();
    fire_shot(1, FR, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_threshold();
    fire_shot(0, DMIN - 1, 1'b0, 1'b0, 1'b0, 1'b0);
    fire_shot(0, DMIN, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_out_of_shots();
    int bc, h0, m0;
    while (m_shots > 0) fire_shot(0, $urandom_range(0, 40), 1'b0, 1'b0, 1'b0, 1'b0);
    h0 = nhit; m0 = nmiss;
    bc = 0;
    wait_ph(2);
    trigger = 1'b1;
    repeat (2 * FR) begin
      step();
      if (busy) bc++;
    end
    checks++;
    if (bc != 0 || shots_left !== 4'd0 || (nhit - h0) != 0 || (nmiss - m0) != 0) begin
      errors++;
      $display("FAIL empty_trigger: busy_cycles=%0d shots=%0d pulses=%0d expected 0/0/0",
               bc, shots_left, (nhit - h0) + (nmiss - m0));
    end
    trigger = 1'b0;
    repeat (4) step();
    do_new_round();
  endtask

  task automatic test_ambient();
    fire_shot(1, 100, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_new_round_at_result();
    fire_shot(0, $urandom_range(DMIN, 40), 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back_trigger();
    int lo, h0, m0, bc, s0;
    if (m_shots == 0) do_new_round();
    fire_shot(0, 20, 1'b0, 1'b1, 1'b1, 1'b0);
    lo = 0;
    repeat (200) begin
      step();
      if (!busy) lo++;
    end
    checks++;
    if (lo != 0) begin
      errors++;
      $display("FAIL hold_cooldown: idle_cycles=%0d expected 0", lo);
    end
    h0 = nhit; m0 = nmiss; s0 = m_shots;
    trigger = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL release_early: busy=%b expected 1 two cycles after release", busy);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL release_3cyc: busy=%b expected 0 three cycles after release", busy);
    end
    bc = 0;
    repeat (2 * FR) begin
      step();
      if (busy) bc++;
    end
    checks++;
    if (bc != 0 || (nhit - h0) + (nmiss - m0) != 0 || shots_left !== 4'(s0)) begin
      errors++;
      $display("FAIL no_queue: busy_cycles=%0d pulses=%0d shots=%0d expected 0/0/%0d",
               bc, (nhit - h0) + (nmiss - m0), shots_left, s0);
    end
  endtask

  task automatic test_random();
    int bn, tn;
    for (int it = 0; it < 6; it++) begin
      if (m_shots == 0) do_new_round();
      bn = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      tn = $urandom_range(0, 40);
      fire_shot(bn, tn, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int h0, m0, bc;
    if (m_shots == 0) do_new_round();
    fire_shot(0, 30, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_ph(2);
    trigger = 1'b1;
    wait_ph(0);
    wait_ph(0);
    wait_ph(50);
    detect = 1'b1;
    repeat (20) step();
    h0 = nhit; m0 = nmiss;
    reset = 1'b1;
    step();
    checks++;
    if (flash_target !== 1'b0 || busy !== 1'b0 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0 ||
        shots_left !== 4'(NSHOT) || score !== '0) begin
      errors++;
      $display("FAIL reset_mid: ft=%b busy=%b hit=%b miss=%b shots=%0d score=%0d expected 0/0/0/0/%0d/0",
               flash_target, busy, hit_pulse, miss_pulse, shots_left, score, NSHOT);
    end
    trigger = 1'b0;
    detect  = 1'b0;
    step();
    reset = 1'b0;
    m_shots = NSHOT;
    m_score = 0;
    bc = 0;
    repeat (2 * FR) begin
      step();
      if (busy) bc++;
    end
    checks++;
    if (bc != 0 || (nhit - h0) + (nmiss - m0) != 0) begin
      errors++;
      $display("FAIL reset_no_pulse: busy_cycles=%0d pulses=%0d expected 0/0",
               bc, (nhit - h0) + (nmiss - m0));
    end
  endtask

  initial begin
    reset     = 1'b1;
    trigger   = 1'b0;
    detect    = 1'b0;
    new_round = 1'b0;
    test_reset();
    test_single_hit();
    test_threshold();
    test_out_of_shots();
    test_ambient();
    test_new_round_at_result();
    test_back_to_back_trigger();
    test_random();
    test_reset_mid();
    checks++;
    if (nboth != 0) begin
      errors++;
      $display("FAIL exclusive_pulses: both_high_cycles=%0d expected 0", nboth);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
